// File: rtl/vc_push_cond_if.sv
// Push-side bundle between the word source/pop logic and vc_push_cond.
// The master drives words and pop strobes; the slave returns push strobes and status.
interface vc_push_cond_if #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             VC0_rd;
    logic             VC1_rd;
    logic             VC0_wr;
    logic             VC1_wr;
    logic [WIDTH-1:0] VC_data;
    logic [CNT_W-1:0] VC0_count;
    logic [CNT_W-1:0] VC1_count;
    logic             pause;
    logic [7:0]       drop_count;

    modport master (
        output data_in, valid_in, VC0_rd, VC1_rd,
        input  VC0_wr, VC1_wr, VC_data, VC0_count, VC1_count, pause, drop_count
    );

    modport slave (
        input  data_in, valid_in, VC0_rd, VC1_rd,
        output VC0_wr, VC1_wr, VC_data, VC0_count, VC1_count, pause, drop_count
    );
endinterface

// File: rtl/vc_push_cond.sv
// Write-side controller for the VC0/VC1 FIFOs: classifies, pushes, tracks occupancy, pauses source.
// Define VC_PUSH_DROP_CNT_EN to build the saturating dropped-word counter.
module vc_push_cond #(
    parameter int WIDTH   = 6,
    parameter int CLS_IDX = 4,
    parameter int DEPTH   = 8,
    parameter int HIGH_WM = 6,
    parameter int LOW_WM  = 2
) (
    input  logic          clk,
    input  logic          reset_L,
    vc_push_cond_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    state_t                state_q;
    logic                  pause_q;
    logic [1:0]            wr_q;
    logic [WIDTH-1:0]      data_q;
    logic [1:0][CNT_W-1:0] count_q;
    logic [1:0][CNT_W-1:0] count_d;
    logic [1:0]            rd;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            full;
    logic                  accept;
    logic                  cls;
    logic                  any_high;
    logic                  both_low;

    assign accept = bus.valid_in && (state_q != ST_INIT);
    assign cls    = bus.data_in[CLS_IDX];
    assign rd     = {bus.VC1_rd, bus.VC0_rd};

    // Room is judged on the current count, so a same-cycle pop never frees space for a push.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_vc
            localparam logic VC_SEL = (gi != 0);
            assign full[gi]    = (count_q[gi] == CNT_W'(DEPTH));
            assign push[gi]    = accept && (cls == VC_SEL) && !full[gi];
            assign pop[gi]     = rd[gi] && (count_q[gi] != '0);
            assign count_d[gi] = count_q[gi] + CNT_W'(push[gi]) - CNT_W'(pop[gi]);
        end
    endgenerate

    assign any_high = (count_d[0] >= CNT_W'(HIGH_WM)) || (count_d[1] >= CNT_W'(HIGH_WM));
    assign both_low = (count_d[0] <= CNT_W'(LOW_WM)) && (count_d[1] <= CNT_W'(LOW_WM));

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_INIT;
            pause_q <= 1'b0;
            wr_q    <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= push;
            count_q <= count_d;
            if (|push) begin
                data_q <= bus.data_in;
            end
            case (state_q)
                ST_INIT: begin
                    state_q <= ST_ACTIVE;
                    pause_q <= 1'b0;
                end
                ST_ACTIVE: begin
                    if (any_high) begin
                        state_q <= ST_PAUSED;
                        pause_q <= 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (both_low) begin
                        state_q <= ST_ACTIVE;
                        pause_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    pause_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.VC0_wr    = wr_q[0];
    assign bus.VC1_wr    = wr_q[1];
    assign bus.VC_data   = data_q;
    assign bus.VC0_count = count_q[0];
    assign bus.VC1_count = count_q[1];
    assign bus.pause     = pause_q;

`ifdef VC_PUSH_DROP_CNT_EN
    logic       drop;
    logic [7:0] drop_q;

    assign drop = accept && (push == 2'b00);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            drop_q <= '0;
        end else if (drop && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign bus.drop_count = drop_q;
`else
    assign bus.drop_count = '0;
`endif

endmodule

// File: tb/tb_vc_push_cond.sv
// Randomized scoreboard bench for vc_push_cond: occupancy/pause/drop model built from the rules,
// expected pushes queued by the driver and retired by an independent monitor.
module tb_vc_push_cond;
    localparam int WIDTH   = 6;
    localparam int CLS_IDX = 4;
    localparam int DEPTH   = 8;
    localparam int HIGH_WM = 6;
    localparam int LOW_WM  = 2;

    typedef struct {
        int vc;
        int data;
    } push_t;

    typedef struct {
        int c0;
        int c1;
        int pause;
        int drop;
        int wr0;
        int wr1;
    } stat_t;

    logic clk = 1'b0;
    logic reset_L = 1'b1;

    push_t push_q[$];
    stat_t stat_q[$];
    int    occ[2];
    bit    paused;
    int    drops;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    always #5 clk = ~clk;

    vc_push_cond_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    vc_push_cond #(
        .WIDTH  (WIDTH),
        .CLS_IDX(CLS_IDX),
        .DEPTH  (DEPTH),
        .HIGH_WM(HIGH_WM),
        .LOW_WM (LOW_WM)
    ) dut (
        .clk    (clk),
        .reset_L(reset_L),
        .bus    (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int exp_drop();
`ifdef VC_PUSH_DROP_CNT_EN
        return (drops > 255) ? 255 : drops;
`else
        return 0;
`endif
    endfunction

    // Apply one cycle of inputs and advance the reference model to the state after the next edge.
    task automatic drive(input bit init, input bit v, input logic [WIDTH-1:0] d,
                         input bit r0, input bit r1);
        int    pu[2];
        bit    rdv[2];
        int    t;
        int    old;
        stat_t s;
        bus.valid_in = v;
        bus.data_in  = d;
        bus.VC0_rd   = r0;
        bus.VC1_rd   = r1;
        pu[0] = 0;
        pu[1] = 0;
        rdv[0] = r0;
        rdv[1] = r1;
        if (!init && v) begin
            t = int'(d[CLS_IDX]);
            if (occ[t] < DEPTH) begin
                pu[t] = 1;
                push_q.push_back('{vc: t, data: int'(d)});
            end else begin
                drops++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            old = occ[i];
            occ[i] = old + pu[i] - ((rdv[i] && old > 0) ? 1 : 0);
        end
        if (!paused && (occ[0] >= HIGH_WM || occ[1] >= HIGH_WM)) begin
            paused = 1'b1;
        end else if (paused && occ[0] <= LOW_WM && occ[1] <= LOW_WM) begin
            paused = 1'b0;
        end
        s.c0 = occ[0];
        s.c1 = occ[1];
        s.pause = paused ? 1 : 0;
        s.drop = exp_drop();
        s.wr0 = pu[0];
        s.wr1 = pu[1];
        stat_q.push_back(s);
    endtask

    task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit r0, input bit r1);
        @(negedge clk);
        drive(1'b0, v, d, r0, r1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Reset lands between edges with a word pending; the first cycle after release offers a word too.
    task automatic do_reset();
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.data_in  = WIDTH'($urandom);
        bus.VC0_rd   = 1'b0;
        bus.VC1_rd   = 1'b0;
        #2;
        mon_en  = 1'b0;
        reset_L = 1'b0;
        #1;
        chk("rst_vc0_wr", bus.VC0_wr, 0);
        chk("rst_vc1_wr", bus.VC1_wr, 0);
        chk("rst_vc_data", bus.VC_data, 0);
        chk("rst_vc0_count", bus.VC0_count, 0);
        chk("rst_vc1_count", bus.VC1_count, 0);
        chk("rst_pause", bus.pause, 0);
        chk("rst_drop_count", bus.drop_count, 0);
        push_q.delete();
        stat_q.delete();
        occ[0] = 0;
        occ[1] = 0;
        paused = 1'b0;
        drops  = 0;
        @(negedge clk);
        reset_L = 1'b1;
        mon_en  = 1'b1;
        drive(1'b1, 1'b1, WIDTH'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin : monitor
        push_t p;
        stat_t s;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (bus.VC0_wr || bus.VC1_wr) begin
                    if (push_q.size() == 0) begin
                        chk("unexpected_wr", {30'd0, bus.VC1_wr, bus.VC0_wr}, 0);
                    end else begin
                        p = push_q.pop_front();
                        chk("push_vc", bus.VC1_wr ? 1 : 0, p.vc);
                        chk("push_data", bus.VC_data, p.data);
                    end
                end
                if (stat_q.size() > 0) begin
                    s = stat_q.pop_front();
                    chk("vc0_wr", bus.VC0_wr, s.wr0);
                    chk("vc1_wr", bus.VC1_wr, s.wr1);
                    chk("vc0_count", bus.VC0_count, s.c0);
                    chk("vc1_count", bus.VC1_count, s.c1);
                    chk("pause", bus.pause, s.pause);
                    chk("drop_count", bus.drop_count, s.drop);
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int rd_pct;
        int v_pct;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.VC0_rd   = 1'b0;
        bus.VC1_rd   = 1'b0;

        // classification: VC1 word then VC0 word
        do_reset();
        step(1'b1, 6'h10, 1'b0, 1'b0);
        step(1'b1, 6'h05, 1'b0, 1'b0);
        idle(2);

        // watermark hysteresis on VC0
        do_reset();
        repeat (6) step(1'b1, 6'h01, 1'b0, 1'b0);
        idle(2);
        repeat (4) step(1'b0, '0, 1'b1, 1'b0);
        idle(2);

        // VC0 overflow
        do_reset();
        repeat (9) step(1'b1, 6'h02, 1'b0, 1'b0);
        idle(2);

        // simultaneous push/pop and pop on empty
        do_reset();
        repeat (3) step(1'b1, 6'h03, 1'b0, 1'b0);
        step(1'b1, 6'h04, 1'b1, 1'b1);
        idle(2);

        // drop counter saturation on VC1
        do_reset();
        repeat (308) step(1'b1, 6'h1F, 1'b0, 1'b0);
        idle(2);

        // random traffic alternating between congested and draining phases
        do_reset();
        for (int i = 0; i < 800; i++) begin
            rd_pct = ((i / 100) % 2 == 0) ? 15 : 55;
            v_pct  = ((i / 100) % 2 == 0) ? 85 : 50;
            step(($urandom % 100) < v_pct, WIDTH'($urandom),
                 ($urandom % 100) < rd_pct, ($urandom % 100) < rd_pct);
            if (i == 400) do_reset();
        end
        idle(3);
        @(negedge clk);
        chk("pending_push", push_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
